spi_cmd_scheduler: RTL and testbench
====================================

// Module: spi_cmd_scheduler
// PURPOSE
//   Command front-end directly upstream of Spi_Protocol. Buffers SPI commands {cs,rw,mode,data} in a FIFO.
//   Issues them one at a time on the master-side inputs: CS, RW, MODE, data_in_to_master.
//   Holds each command for a fixed transfer window, then captures data_out_from_master.
//   Returns the captured byte on a valid/ready response port.
// PARAMETERS
//   DEPTH        4      command FIFO entries; power of two, >=2
//   XFER_CYCLES  18     clk cycles the command is held in XFER state; >=1
//   IDLE_CS      2'b00  value driven on spi_cs when no transfer is in flight
// PORTS
//   clk          in   1   single clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   cmd_valid    in   1   command offered
//   cmd_ready    out  1   command accepted when cmd_valid&&cmd_ready
//   cmd_cs       in   2   target chip-select code
//   cmd_rw       in   2   read/write code
//   cmd_mode     in   2   SPI mode (CPOL/CPHA)
//   cmd_data     in   8   byte to transmit
//   spi_cs       out  2   to Spi_Protocol CS
//   spi_rw       out  2   to Spi_Protocol RW
//   spi_mode     out  2   to Spi_Protocol MODE
//   spi_data     out  8   to Spi_Protocol data_in_to_master
//   spi_rdata    in   8   from Spi_Protocol data_out_from_master
//   rsp_valid    out  1   response byte available
//   rsp_ready    in   1   response consumed when rsp_valid&&rsp_ready
//   rsp_data     out  8   captured byte
//   rsp_cs       out  2   cs code of the command that produced rsp_data
//   fifo_count   out  $clog2(DEPTH)+1   buffered commands, 0..DEPTH
//   busy         out  1   (state!=IDLE)||(fifo_count!=0)
//   err          out  1   sticky error flag; see CONFIGURATION
// BEHAVIOUR
//   Reset (reset==0, async):
//   - Outputs: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_cs=0, spi_cs=IDLE_CS, spi_rw=0, spi_mode=0,
//     spi_data=0, fifo_count=0, busy=0, err=0.
//   - State: FSM=IDLE, FIFO pointers=0.
//   FIFO:
//   - cmd_ready = (fifo_count<DEPTH), combinational from count only; push refused when full even if a pop occurs that cycle.
//   - Simultaneous push+pop when not full: count unchanged.
//   - Pointers wrap modulo DEPTH. Ordering is strict FIFO.
//   FSM {IDLE, LOAD, XFER, RESP}; all outputs registered:
//   - IDLE: spi_cs=IDLE_CS, spi_rw=0, spi_data=0, spi_mode holds the last issued mode.
//     fifo_count!=0 -> pop head; next state LOAD.
//   - LOAD: spi_* driven with the popped command on the edge entering LOAD; counter=XFER_CYCLES-1; next state XFER.
//   - XFER: spi_* held; counter decrements.
//     At counter==0 edge: rsp_data<=spi_rdata, rsp_cs<=cmd cs, rsp_valid<=1.
//     spi_cs/rw/data return to idle values; next state RESP.
//   - RESP: rsp_valid, rsp_data and rsp_cs are stable until handshake.
//     On handshake: rsp_valid<=0; next state IDLE.
//     Always at least one IDLE cycle between transfers (CS framing gap).
//   Timing:
//   - spi_* carry a command for exactly 1+XFER_CYCLES cycles.
//   - Push into empty idle block at edge T: LOAD at T+1, rsp_valid at T+2+XFER_CYCLES.
//   - spi_rdata is sampled only on the final XFER cycle.
//   Reset mid-operation: in-flight transfer abandoned, no response, FIFO emptied, spi_cs=IDLE_CS immediately.
// CONFIGURATION
//   SPI_SCHED_ERR_EN defined:
//   - An accepted command with cmd_cs==2'b11 (no slave) is dropped, not written into the FIFO.
//   - It still completes the handshake; err<=1 (sticky until reset).
//   SPI_SCHED_ERR_EN undefined:
//   - cs==2'b11 commands are queued and issued normally; err tied 0.
// TESTING
//   1. Assert reset low mid-run -> all outputs at reset values same cycle, cmd_ready=1, busy=0.
//   2. Push {cs=1,rw=1,mode=0,data=8'hA5}, spi_rdata=8'h3C, rsp_ready=1 ->
//      spi_cs=1/spi_data=A5 for exactly 19 cycles, then rsp_valid=1 with rsp_data=3C, rsp_cs=1.
//   3. rsp_ready=0, push 6 cmds back-to-back -> 1 popped, fifo_count=4, cmd_ready=0, 6th stalls.
//      After the first response handshake the 6th is accepted; responses arrive in push order.
//   4. Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_data stable, spi_cs=IDLE_CS, no LOAD.
//   5. Reset low at XFER cycle 5 -> spi_cs=IDLE_CS at once.
//      After release, no rsp_valid and fifo_count=0.
//   6. Push cs=2'b11:
//      - With SPI_SCHED_ERR_EN: err=1, fifo_count unchanged, no transfer.
//      - Without it: transfer issued with spi_cs=3, err=0.

Source files
------------

// File: rtl/spi_cmd_scheduler.sv
// Command FIFO and transfer sequencer feeding Spi_Protocol; returns the captured byte per command.
// Optional: define SPI_SCHED_ERR_EN to drop cs==2'b11 commands and raise a sticky err flag.
module spi_cmd_scheduler #(
  parameter int         DEPTH       = 4,
  parameter int         XFER_CYCLES = 18,
  parameter logic [1:0] IDLE_CS     = 2'b00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_cs,
  input  logic [1:0]               cmd_rw,
  input  logic [1:0]               cmd_mode,
  input  logic [7:0]               cmd_data,
  output logic [1:0]               spi_cs,
  output logic [1:0]               spi_rw,
  output logic [1:0]               spi_mode,
  output logic [7:0]               spi_data,
  input  logic [7:0]               spi_rdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic [1:0]               rsp_cs,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
  localparam logic [AW:0]  FULL     = (AW+1)'(DEPTH);
  localparam logic [CNW-1:0] CNT_LD = CNW'(XFER_CYCLES - 1);

  typedef struct packed {
    logic [1:0] cs;
    logic [1:0] rw;
    logic [1:0] mode;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, LOAD, XFER, RESP} state_t;

  state_t         state_q, state_d;
  cmd_t           mem_q [DEPTH];
  cmd_t           mem_d [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]    count_q, count_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic [1:0]     spi_cs_q, spi_cs_d, spi_rw_q, spi_rw_d, spi_mode_q, spi_mode_d;
  logic [7:0]     spi_data_q, spi_data_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic [1:0]     rsp_cs_q, rsp_cs_d;
  logic           drop, push, pop;
  cmd_t           head;

`ifdef SPI_SCHED_ERR_EN
  logic err_q, err_d;
  assign drop = (cmd_cs == 2'b11);
  always_comb err_d = err_q | (cmd_valid & cmd_ready & drop);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign drop = 1'b0;
  assign err  = 1'b0;
`endif

  // Readiness depends on count only, so a same-cycle pop never frees a slot early.
  assign cmd_ready = (count_q != FULL);
  assign push      = cmd_valid & cmd_ready & ~drop;
  assign head      = mem_q[rptr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    spi_cs_d    = spi_cs_q;
    spi_rw_d    = spi_rw_q;
    spi_mode_d  = spi_mode_q;
    spi_data_d  = spi_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_cs_d    = rsp_cs_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop        = 1'b1;
        spi_cs_d   = head.cs;
        spi_rw_d   = head.rw;
        spi_mode_d = head.mode;
        spi_data_d = head.data;
        state_d    = LOAD;
      end
      LOAD: begin
        cnt_d   = CNT_LD;
        state_d = XFER;
      end
      XFER: if (cnt_q == '0) begin
        rsp_data_d  = spi_rdata;
        rsp_cs_d    = spi_cs_q;
        rsp_valid_d = 1'b1;
        spi_cs_d    = IDLE_CS;
        spi_rw_d    = 2'b00;
        spi_data_d  = 8'h00;
        state_d     = RESP;
      end else begin
        cnt_d = cnt_q - CNW'(1);
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    if (push) begin
      mem_d[wptr_q] = '{cs: cmd_cs, rw: cmd_rw, mode: cmd_mode, data: cmd_data};
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      spi_cs_q    <= IDLE_CS;
      spi_rw_q    <= 2'b00;
      spi_mode_q  <= 2'b00;
      spi_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_cs_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      spi_cs_q    <= spi_cs_d;
      spi_rw_q    <= spi_rw_d;
      spi_mode_q  <= spi_mode_d;
      spi_data_q  <= spi_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cs_q    <= rsp_cs_d;
    end
  end

  assign spi_cs     = spi_cs_q;
  assign spi_rw     = spi_rw_q;
  assign spi_mode   = spi_mode_q;
  assign spi_data   = spi_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_cs     = rsp_cs_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Scoreboarded bench for spi_cmd_scheduler: echoing slave model, queue of expected responses.
// Honours SPI_SCHED_ERR_EN the same way as the design.
module tb_spi_cmd_scheduler;
  logic       clk = 1'b0, reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_cs = 2'b00, cmd_rw = 2'b00, cmd_mode = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [1:0] spi_cs, spi_rw, spi_mode;
  logic [7:0] spi_data, spi_rdata;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [1:0] rsp_cs;
  logic [2:0] fifo_count;
  logic       busy, err;

  int         n_vec = 0, n_err = 0;
  logic [9:0] exp_q[$];
  bit         err_exp = 1'b0, rand_rdy = 1'b0, echo = 1'b1;
  logic [7:0] rdata_drv = 8'h00;

  spi_cmd_scheduler dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_cs(cmd_cs), .cmd_rw(cmd_rw), .cmd_mode(cmd_mode), .cmd_data(cmd_data),
    .spi_cs(spi_cs), .spi_rw(spi_rw), .spi_mode(spi_mode), .spi_data(spi_data),
    .spi_rdata(spi_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cs(rsp_cs), .fifo_count(fifo_count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Slave answers with a byte derived from whatever command is on the bus.
  assign spi_rdata = echo ? (~spi_data ^ {2'b00, spi_rw, spi_mode, spi_cs}) : rdata_drv;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_cs"}, rsp_cs, 0);
    chk({tag, "_spi_cs"}, spi_cs, 0);
    chk({tag, "_spi_rw"}, spi_rw, 0);
    chk({tag, "_spi_mode"}, spi_mode, 0);
    chk({tag, "_spi_data"}, spi_data, 0);
    chk({tag, "_fifo_count"}, fifo_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Offer one command until accepted; on acceptance record the expected response.
  task automatic push(input logic [1:0] cs, input logic [1:0] rw, input logic [1:0] md,
                      input logic [7:0] d, input bit ovr, input logic [7:0] od);
    int t = 0;
    bit acc = 1'b0;
    cmd_valid = 1'b1; cmd_cs = cs; cmd_rw = rw; cmd_mode = md; cmd_data = d;
    while (!acc && t < 2000) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1; t++;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
`ifdef SPI_SCHED_ERR_EN
    else if (cs == 2'b11) err_exp = 1'b1;
`endif
    else exp_q.push_back({cs, ovr ? od : (~d ^ {2'b00, rw, md, cs})});
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin step(); t++; end
    chk("drain_timeout", (t < 3000), 1);
  endtask

  // Monitor: every response handshake is checked against the head of the model queue.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", {rsp_cs, rsp_data}, 10'h3ff);
      else chk("rsp", {rsp_cs, rsp_data}, exp_q.pop_front());
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_cyc;
    logic [1:0] rc;
    #1 chk_reset("rst0");
    repeat (3) step();
    @(negedge clk) reset = 1'b1;
    step();

    // Single transfer with a byte presented only on the final XFER cycle.
    echo = 1'b0; rdata_drv = 8'h00; rsp_ready = 1'b1;
    push(2'd1, 2'd1, 2'd0, 8'hA5, 1'b1, 8'h3C);
    cs_cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) chk("t2_spi_data", spi_data, 8'hA5);
      if (spi_cs == 2'd1) cs_cyc++;
      if (k == 19) begin chk("t2_no_early_rsp", rsp_valid, 0); rdata_drv = 8'h3C; end
      if (k == 20) begin
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_data", rsp_data, 8'h3C);
        chk("t2_rsp_cs", rsp_cs, 1);
        chk("t2_spi_cs_idle", spi_cs, 0);
        rdata_drv = 8'h00;
      end
    end
    chk("t2_cs_window", cs_cyc, 19);
    drain();
    echo = 1'b1;

    // Back-pressure: fill the FIFO behind a stalled response.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(2'd1, 2'($urandom), 2'($urandom), 8'($urandom), 1'b0, 8'h00);
    chk("t3_count_full", fifo_count, 4);
    chk("t3_ready_low", cmd_ready, 0);
    repeat (30) step();
    chk("t3_rsp_pending", rsp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_rsp_stable", rsp_data, exp_q[0][7:0]);
      chk("t4_no_load", spi_cs, 0);
      chk("t4_count_hold", fifo_count, 4);
      step();
    end
    fork
      push(2'd1, 2'($urandom), 2'($urandom), 8'($urandom), 1'b0, 8'h00);
      begin repeat (3) step(); chk("t3_sixth_stalled", fifo_count, 4); rsp_ready = 1'b1; end
    join
    drain();

    // No-slave chip select.
    rsp_ready = 1'b1;
    push(2'd3, 2'd2, 2'd1, 8'h77, 1'b0, 8'h00);
`ifdef SPI_SCHED_ERR_EN
    chk("t6_err_set", err, 1);
    chk("t6_count", fifo_count, 0);
    step();
    chk("t6_no_xfer", spi_cs, 0);
    chk("t6_idle", busy, 0);
`else
    step();
    chk("t6_spi_cs3", spi_cs, 3);
    chk("t6_err_zero", err, 0);
`endif
    drain();

    // Randomised traffic with random response back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rc = 2'($urandom);
      push(rc, 2'($urandom), 2'($urandom), 8'($urandom), 1'b0, 8'h00);
      repeat ($urandom_range(0, 4)) step();
    end
    rand_rdy = 1'b0;
    step();
    rsp_ready = 1'b1;
    drain();
    chk("rand_err", err, err_exp);

    // Reset during XFER abandons everything.
    push(2'd1, 2'd1, 2'd2, 8'h5A, 1'b0, 8'h00);
    repeat (7) step();
    chk("t5_in_xfer", spi_cs, 1);
    #2 reset = 1'b0;
    #1 chk_reset("t5");
    exp_q.delete();
    err_exp = 1'b0;
    repeat (2) step();
    @(negedge clk) reset = 1'b1;
    repeat (40) step();
    chk("t5_no_rsp", rsp_valid, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
